// File: rtl/alu_control_sequencer.sv
// Hardwired fetch / register-register execute sequencer for the 32-bit bus datapath.
// Optional feature: define CTRL_MULDIV_EN to enable mul/div (T6, LO then HI writeback).
module alu_control_sequencer #(
    parameter int unsigned FETCH_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_rdy,
    input  logic [31:0] ir,
    output logic [15:0] reg_out,
    output logic [15:0] reg_in,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mdr_out,
    output logic        mdr_in,
    output logic        mdr_read,
    output logic        ir_in,
    output logic        y_in,
    output logic        zhi_in,
    output logic        zlo_in,
    output logic        zhi_out,
    output logic        zlo_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic [3:0]  state
);

    localparam int unsigned CW = $clog2(FETCH_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(FETCH_WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;

    logic [4:0]  opcode;
    logic [15:0] ra_sel, rb_sel, rc_sel;
    logic        legal, unary;
    logic [3:0]  dec_op;
`ifdef CTRL_MULDIV_EN
    logic        muldiv;
`endif
    logic        unused_ir_bits;

    assign opcode         = ir[31:27];
    assign ra_sel         = 16'h0001 << ir[26:23];
    assign rb_sel         = 16'h0001 << ir[22:19];
    assign rc_sel         = 16'h0001 << ir[18:15];
    assign unused_ir_bits = ^ir[14:0];
    assign state          = cur;

    // ALU codes are contiguous with the opcode map, offset by 10.
    always_comb begin
        legal  = 1'b0;
        unary  = 1'b0;
        dec_op = 4'(opcode - 5'd10);
`ifdef CTRL_MULDIV_EN
        muldiv = 1'b0;
`endif
        case (opcode)
            5'b01010, 5'b01011, 5'b01100,
            5'b01101, 5'b01110, 5'b01111: legal = 1'b1;
`ifdef CTRL_MULDIV_EN
            5'b10000, 5'b10001: begin
                legal  = 1'b1;
                muldiv = 1'b1;
            end
`endif
            5'b10010, 5'b10011: begin
                legal = 1'b1;
                unary = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cur      <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        nxt      = cur;
        wait_nxt = '0;
        reg_out  = '0;
        reg_in   = '0;
        pc_out   = 1'b0;
        pc_in    = 1'b0;
        inc_pc   = 1'b0;
        mdr_out  = 1'b0;
        mdr_in   = 1'b0;
        mdr_read = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        zhi_in   = 1'b0;
        zlo_in   = 1'b0;
        zhi_out  = 1'b0;
        zlo_out  = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        alu_op   = '0;
        halted   = 1'b0;
        case (cur)
            S_IDLE: if (run) nxt = S_T0;
            S_T0: begin
                pc_out = 1'b1;
                inc_pc = 1'b1;
                zlo_in = 1'b1;
                zhi_in = 1'b1;
                alu_op = 4'd10;
                nxt    = S_T1;
            end
            S_T1: begin
                zlo_out  = 1'b1;
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
                pc_in    = (wait_cnt == '0);
                if (mem_rdy)
                    nxt = S_T2;
                else if (wait_cnt == WAIT_LAST)
                    nxt = S_HALT;
                else
                    wait_nxt = wait_cnt + 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                nxt     = S_T3;
            end
            S_T3: begin
                if (legal) begin
                    reg_out = rb_sel;
                    y_in    = 1'b1;
                    nxt     = S_T4;
                end else begin
                    nxt = S_HALT;
                end
            end
            S_T4: begin
                reg_out = unary ? rb_sel : rc_sel;
                alu_op  = dec_op;
                zlo_in  = 1'b1;
                zhi_in  = 1'b1;
                nxt     = S_T5;
            end
            S_T5: begin
                zlo_out = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (muldiv) begin
                    lo_in = 1'b1;
                    nxt   = S_T6;
                end else begin
                    reg_in = ra_sel;
                    nxt    = run ? S_T0 : S_IDLE;
                end
`else
                reg_in = ra_sel;
                nxt    = run ? S_T0 : S_IDLE;
`endif
            end
`ifdef CTRL_MULDIV_EN
            S_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                nxt     = run ? S_T0 : S_IDLE;
            end
`endif
            S_HALT: halted = 1'b1;
            default: nxt = S_IDLE;
        endcase
    end

endmodule
